// File: rtl/stereo_pkg.sv
// rtl/stereo_pkg.sv - shared sizes, state encoding and pixel square helper for the stereo pixel server
package stereo_pkg;

  localparam int PIX_W   = 3;
  localparam int F_COLS  = 16;
  localparam int G_COLS  = 79;
  localparam int ROWS    = 16;
  localparam int F_DEPTH = 256;
  localparam int G_DEPTH = 1264;
  localparam int F_AW    = 8;
  localparam int G_AW    = 11;
  localparam int XW      = 7;
  localparam int YW      = 4;
  localparam int SQ_W    = 2 * PIX_W;

  typedef enum logic [1:0] {
    LOAD_F = 2'd0,
    LOAD_G = 2'd1,
    SERVE  = 2'd2
  } state_t;

  function automatic logic [SQ_W-1:0] pix_square(input logic [PIX_W-1:0] p);
    logic [SQ_W-1:0] w;
    w = SQ_W'(p);
    return w * w;
  endfunction

endpackage

// File: rtl/stereo_pixel_server_if.sv
// rtl/stereo_pixel_server_if.sv - loader stream and window-scan pixel bus between scanner side and server
interface stereo_pixel_server_if;
  import stereo_pkg::*;

  logic [PIX_W-1:0] pix_in;
  logic             pix_valid;
  logic             pix_ready;
  logic [XW-1:0]    vector_xf;
  logic [XW-1:0]    vector_xg;
  logic [YW-1:0]    vector_y;
  logic             frame_done;
  logic             frame_ready;
  logic [PIX_W-1:0] getfdata;
  logic [PIX_W-1:0] gdata;
  logic [SQ_W-1:0]  get2f;

  modport master (
    output pix_in, pix_valid, vector_xf, vector_xg, vector_y, frame_done,
    input  pix_ready, frame_ready, getfdata, gdata, get2f
  );

  modport slave (
    input  pix_in, pix_valid, vector_xf, vector_xg, vector_y, frame_done,
    output pix_ready, frame_ready, getfdata, gdata, get2f
  );

endinterface

// File: rtl/stereo_pixel_ram.sv
// rtl/stereo_pixel_ram.sv - single write port, registered read port pixel store (read-before-write)
module stereo_pixel_ram #(
  parameter int DEPTH = 256,
  parameter int WIDTH = 3,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/stereo_pixel_server.sv
// rtl/stereo_pixel_server.sv - stereo frame store answering window-scan addresses
// Optional STEREO_PINGPONG_EN: two banks per image so a new frame loads while the current one is served.
module stereo_pixel_server
  import stereo_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  stereo_pixel_server_if.slave bus
);

  state_t            state, state_next;
  logic [G_AW-1:0]   cnt, cnt_next;
  logic              beat, f_we, g_we, load_done;
  logic              rdy_q;
  logic              frame_ready_int;

  logic [F_AW-1:0]   f_raddr;
  logic [G_AW-1:0]   g_raddr, g_lin, y_ext;
  logic              f_in, g_in, f_ok, g_ok;
  logic [PIX_W-1:0]  f_rd, g_rd, f_pix, g_pix;

  assign beat          = bus.pix_valid & rdy_q;
  assign bus.pix_ready = rdy_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= LOAD_F;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    f_we       = 1'b0;
    g_we       = 1'b0;
    load_done  = 1'b0;
    unique case (state)
      LOAD_F: begin
        if (beat) begin
          f_we = 1'b1;
          if (cnt == G_AW'(F_DEPTH - 1)) begin
            state_next = LOAD_G;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt + 1'b1;
          end
        end
      end
      LOAD_G: begin
        if (beat) begin
          g_we = 1'b1;
          if (cnt == G_AW'(G_DEPTH - 1)) begin
            load_done = 1'b1;
            cnt_next  = '0;
`ifdef STEREO_PINGPONG_EN
            state_next = LOAD_F;
`else
            state_next = SERVE;
`endif
          end else begin
            cnt_next = cnt + 1'b1;
          end
        end
      end
      SERVE: begin
`ifndef STEREO_PINGPONG_EN
        if (bus.frame_done) begin
          state_next = LOAD_F;
        end
`endif
      end
      default: state_next = LOAD_F;
    endcase
  end

  // Address arithmetic: F is a plain concatenation, G uses y*79 = y*64 + y*16 - y.
  assign f_in    = bus.vector_xf < XW'(F_COLS);
  assign g_in    = bus.vector_xg < XW'(G_COLS);
  assign f_raddr = {bus.vector_y, bus.vector_xf[3:0]};
  assign y_ext   = G_AW'(bus.vector_y);
  assign g_lin   = (y_ext << 6) + (y_ext << 4) - y_ext + G_AW'(bus.vector_xg);
  assign g_raddr = g_in ? g_lin : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      f_ok <= 1'b0;
      g_ok <= 1'b0;
    end else begin
      f_ok <= f_in;
      g_ok <= g_in;
    end
  end

`ifdef STEREO_PINGPONG_EN
  logic [1:0]       full, full_next;
  logic             wr_sel, rd_sel, wr_sel_next, rd_sel_next, rd_sel_q;
  logic [PIX_W-1:0] f_rd_bank [2];
  logic [PIX_W-1:0] g_rd_bank [2];

  always_comb begin
    full_next   = full;
    wr_sel_next = wr_sel;
    rd_sel_next = rd_sel;
    if (load_done) begin
      full_next[wr_sel] = 1'b1;
      wr_sel_next       = ~wr_sel;
    end
    // Completion and release never target the same bank: one is empty, the other full.
    if (bus.frame_done && full[rd_sel]) begin
      full_next[rd_sel] = 1'b0;
      rd_sel_next       = ~rd_sel;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full     <= '0;
      wr_sel   <= 1'b0;
      rd_sel   <= 1'b0;
      rd_sel_q <= 1'b0;
      rdy_q    <= 1'b0;
    end else begin
      full     <= full_next;
      wr_sel   <= wr_sel_next;
      rd_sel   <= rd_sel_next;
      rd_sel_q <= rd_sel;
      rdy_q    <= ~full_next[wr_sel_next];
    end
  end

  assign frame_ready_int = full[rd_sel];

  for (genvar b = 0; b < 2; b++) begin : g_bank
    stereo_pixel_ram #(.DEPTH(F_DEPTH), .WIDTH(PIX_W), .AW(F_AW)) u_f_ram (
      .clk   (clk),
      .we    (f_we && (wr_sel == 1'(b))),
      .waddr (cnt[F_AW-1:0]),
      .wdata (bus.pix_in),
      .raddr (f_raddr),
      .rdata (f_rd_bank[b])
    );
    stereo_pixel_ram #(.DEPTH(G_DEPTH), .WIDTH(PIX_W), .AW(G_AW)) u_g_ram (
      .clk   (clk),
      .we    (g_we && (wr_sel == 1'(b))),
      .waddr (cnt),
      .wdata (bus.pix_in),
      .raddr (g_raddr),
      .rdata (g_rd_bank[b])
    );
  end

  assign f_rd = f_rd_bank[rd_sel_q];
  assign g_rd = g_rd_bank[rd_sel_q];
`else
  logic frame_ready_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_ready_q <= 1'b0;
      rdy_q         <= 1'b0;
    end else begin
      rdy_q <= (state_next != SERVE);
      if (load_done) begin
        frame_ready_q <= 1'b1;
      end else if (state == SERVE && bus.frame_done) begin
        frame_ready_q <= 1'b0;
      end
    end
  end

  assign frame_ready_int = frame_ready_q;

  stereo_pixel_ram #(.DEPTH(F_DEPTH), .WIDTH(PIX_W), .AW(F_AW)) u_f_ram (
    .clk   (clk),
    .we    (f_we),
    .waddr (cnt[F_AW-1:0]),
    .wdata (bus.pix_in),
    .raddr (f_raddr),
    .rdata (f_rd)
  );

  stereo_pixel_ram #(.DEPTH(G_DEPTH), .WIDTH(PIX_W), .AW(G_AW)) u_g_ram (
    .clk   (clk),
    .we    (g_we),
    .waddr (cnt),
    .wdata (bus.pix_in),
    .raddr (g_raddr),
    .rdata (g_rd)
  );
`endif

  assign f_pix           = f_ok ? f_rd : '0;
  assign g_pix           = g_ok ? g_rd : '0;
  assign bus.getfdata    = f_pix;
  assign bus.gdata       = g_pix;
  assign bus.get2f       = pix_square(f_pix);
  assign bus.frame_ready = frame_ready_int;

endmodule

// File: tb/tb_stereo_pixel_server.sv
// tb/tb_stereo_pixel_server.sv - randomized self-checking bench against an array model of the frame pair
module tb_stereo_pixel_server;
  import stereo_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  stereo_pixel_server_if bus();

  stereo_pixel_server dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [2:0] f_cur [256];
  logic [2:0] g_cur [1264];
  logic [2:0] f_new [256];
  logic [2:0] g_new [1264];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic read_check(input int xf, input int xg, input int y);
    int ef, eg;
    bus.vector_xf = 7'(xf);
    bus.vector_xg = 7'(xg);
    bus.vector_y  = 4'(y);
    @(posedge clk);
    @(negedge clk);
    ef = (xf < 16) ? int'(f_cur[y * 16 + xf]) : 0;
    eg = (xg < 79) ? int'(g_cur[y * 79 + xg]) : 0;
    chk("getfdata", bus.getfdata, ef);
    chk("gdata", bus.gdata, eg);
    chk("get2f", bus.get2f, ef * ef);
  endtask

  task automatic random_reads(input int n);
    for (int k = 0; k < n; k++) begin
      read_check($urandom_range(0, 20), $urandom_range(60, 90), $urandom_range(0, 15));
    end
  endtask

  task automatic pulse_frame_done();
    bus.frame_done = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.frame_done = 1'b0;
  endtask

  task automatic copy_frame();
    for (int i = 0; i < 256; i++) f_cur[i] = f_new[i];
    for (int i = 0; i < 1264; i++) g_cur[i] = g_new[i];
  endtask

  // Streams F then G; pattern=1 uses the i%8 / 3i%8 images with no valid gaps.
  task automatic load_frame(input bit pattern, input bit exp_fr, input bit rbw);
    int waits;
    for (int i = 0; i < 256; i++) f_new[i] = pattern ? 3'(i % 8) : 3'($urandom);
    for (int i = 0; i < 1264; i++) g_new[i] = pattern ? 3'((i * 3) % 8) : 3'($urandom);
    if (rbw) g_new[1263] = g_cur[1263] ^ 3'd1;
    bus.vector_xf = 7'd0;
    bus.vector_xg = 7'd78;
    bus.vector_y  = 4'd15;
    for (int i = 0; i < 1520; i++) begin
      if (!pattern && $urandom_range(0, 3) == 0) begin
        bus.pix_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
      end
      bus.pix_in     = (i < 256) ? f_new[i] : g_new[i - 256];
      bus.pix_valid  = 1'b1;
      bus.frame_done = (!pattern && !exp_fr && i == 600);
      waits = 0;
      while (bus.pix_ready !== 1'b1 && waits < 50) begin
        @(posedge clk);
        @(negedge clk);
        waits++;
      end
      if (waits == 50) begin
        chk("pix_ready_timeout", 0, 1);
        bus.pix_valid = 1'b0;
        return;
      end
      if (i == 1519) chk("frame_ready_before_last", bus.frame_ready, exp_fr);
      @(posedge clk);
      @(negedge clk);
      bus.frame_done = 1'b0;
    end
    bus.pix_valid = 1'b0;
    chk("frame_ready_after_load", bus.frame_ready, 1);
    if (rbw) chk("gdata_read_before_write", bus.gdata, g_cur[1263]);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst            = 1'b1;
    bus.pix_in     = '0;
    bus.pix_valid  = 1'b0;
    bus.vector_xf  = '0;
    bus.vector_xg  = '0;
    bus.vector_y   = '0;
    bus.frame_done = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("reset_pix_ready", bus.pix_ready, 0);
    chk("reset_frame_ready", bus.frame_ready, 0);
    chk("reset_getfdata", bus.getfdata, 0);
    chk("reset_gdata", bus.gdata, 0);
    chk("reset_get2f", bus.get2f, 0);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("pix_ready_after_reset", bus.pix_ready, 1);

    load_frame(1'b1, 1'b0, 1'b0);
    copy_frame();
    read_check(5, 0, 2);
    chk("f_5_2_value", bus.getfdata, 5);
    chk("f_5_2_square", bus.get2f, 25);
    read_check(0, 78, 15);
    chk("g_78_15_value", bus.gdata, 5);
    read_check(16, 79, 3);
    read_check(15, 0, 0);
    read_check(127, 127, 15);

`ifdef STEREO_PINGPONG_EN
    chk("pp_pix_ready_serving", bus.pix_ready, 1);
    random_reads(20);
    load_frame(1'b0, 1'b1, 1'b0);
    chk("pp_pix_ready_both_full", bus.pix_ready, 0);
    random_reads(20);
    pulse_frame_done();
    chk("pp_frame_ready_swap", bus.frame_ready, 1);
    chk("pp_pix_ready_after_swap", bus.pix_ready, 1);
    copy_frame();
    random_reads(30);
    pulse_frame_done();
    chk("pp_frame_ready_drained", bus.frame_ready, 0);
`else
    chk("serve_pix_ready", bus.pix_ready, 0);
    random_reads(20);
    pulse_frame_done();
    chk("frame_done_frame_ready", bus.frame_ready, 0);
    chk("frame_done_pix_ready", bus.pix_ready, 1);
    load_frame(1'b0, 1'b0, 1'b1);
    copy_frame();
    random_reads(30);

    pulse_frame_done();
    for (int i = 0; i < 100; i++) begin
      bus.pix_in    = 3'($urandom);
      bus.pix_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
    end
    bus.pix_valid = 1'b0;
    bus.vector_xf = 7'd3;
    bus.vector_xg = 7'd3;
    bus.vector_y  = 4'd3;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midload_reset_frame_ready", bus.frame_ready, 0);
    chk("midload_reset_getfdata", bus.getfdata, 0);
    chk("midload_reset_gdata", bus.gdata, 0);
    chk("midload_reset_get2f", bus.get2f, 0);
    rst = 1'b0;
    load_frame(1'b0, 1'b0, 1'b1);
    copy_frame();
    random_reads(20);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
